map_draw_engine: RTL

- Parametrised background-map blitter. Streams a selected map image from an external synchronous colour ROM into VGA memory as (x, y, colour, write) beats.
- Successor to the single-map drawer. Adds configurable map size and screen origin, multi-map selection, and a start/busy/done handshake.
- Compensates for the 1-cycle ROM read latency so x, y and colour are always aligned, and supports stalling through a hold input.
- Sits between the game control FSM and the VGA memory write port.

---
 rtl/map_draw_engine.sv | 139 +++++++++++++
 1 files changed

// File: rtl/map_draw_engine.sv
// rtl/map_draw_engine.sv - background-map blitter from synchronous colour ROM to VGA write port
// Optional macro MAP_DRAW_TRANSPARENT_EN suppresses writes of pixels equal to TRANSPARENT_KEY.
module map_draw_engine #(
    parameter int MAP_W    = 256,
    parameter int MAP_H    = 176,
    parameter int X_ORIGIN = 31,
    parameter int Y_ORIGIN = 31,
    parameter int NUM_MAPS = 4,
    parameter int COLOUR_W = 6,
    parameter int X_W      = 9,
    parameter int Y_W      = 8,
    parameter int ADDR_W   = 18
`ifdef MAP_DRAW_TRANSPARENT_EN
    ,parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = '0
`endif
    ,localparam int SEL_W  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [SEL_W-1:0]    map_sel,
    input  logic                hold,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_q,
    output logic [X_W-1:0]      x_pos,
    output logic [Y_W-1:0]      y_pos,
    output logic [COLOUR_W-1:0] colour,
    output logic                VGA_write,
    output logic                busy,
    output logic                draw_done
);

    localparam int COL_W   = $clog2(MAP_W);
    localparam int ROW_W   = (MAP_H > 1) ? $clog2(MAP_H) : 1;
    localparam int MAP_PIX = MAP_W * MAP_H;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAW, S_DONE} state_t;

    state_t              r_state, w_next;
    logic [SEL_W-1:0]    r_sel, w_sel_clamped;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [ADDR_W-1:0]   r_addr, w_base_new, w_last_addr;
    logic                r_stalled;
    logic [COLOUR_W-1:0] r_hold_q, w_colour;
    logic                w_last_col, w_last_pix, w_write;

`ifndef SYNTHESIS
    if (X_ORIGIN + MAP_W - 1 >= (1 << X_W)) begin : g_x_range_err
        $error("map_draw_engine: X_ORIGIN+MAP_W-1 does not fit in X_W");
    end
    if (Y_ORIGIN + MAP_H - 1 >= (1 << Y_W)) begin : g_y_range_err
        $error("map_draw_engine: Y_ORIGIN+MAP_H-1 does not fit in Y_W");
    end
`endif

    always_comb begin
        w_sel_clamped = map_sel;
        if (int'(map_sel) > NUM_MAPS - 1)
            w_sel_clamped = SEL_W'(NUM_MAPS - 1);
    end

    assign w_base_new  = ADDR_W'(w_sel_clamped) * ADDR_W'(MAP_PIX);
    assign w_last_addr = ADDR_W'(r_sel) * ADDR_W'(MAP_PIX) + ADDR_W'(MAP_PIX - 1);
    assign w_last_col  = (r_col == COL_W'(MAP_W - 1));
    assign w_last_pix  = w_last_col && (r_row == ROW_W'(MAP_H - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: if (!hold) w_next = S_DRAW;
            S_DRAW:  if (!hold && w_last_pix) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_addr    <= '0;
            r_stalled <= 1'b0;
            r_hold_q  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sel  <= w_sel_clamped;
                        r_addr <= w_base_new;
                        r_col  <= '0;
                        r_row  <= '0;
                    end
                end
                S_FETCH: begin
                    if (!hold) r_addr <= r_addr + 1'b1;
                end
                S_DRAW: begin
                    if (!hold) begin
                        if (r_addr != w_last_addr) r_addr <= r_addr + 1'b1;
                        if (w_last_col) begin
                            r_col <= '0;
                            r_row <= w_last_pix ? '0 : r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // The ROM keeps reading one pixel ahead during a stall, so the pending
            // pixel's colour is captured on the first stalled cycle and replayed.
            r_stalled <= (r_state == S_DRAW) && hold;
            if ((r_state == S_DRAW) && hold && !r_stalled)
                r_hold_q <= rom_q;
        end
    end

    assign w_colour = r_stalled ? r_hold_q : rom_q;

`ifdef MAP_DRAW_TRANSPARENT_EN
    assign w_write = (r_state == S_DRAW) && !hold && (w_colour != TRANSPARENT_KEY);
`else
    assign w_write = (r_state == S_DRAW) && !hold;
`endif

    assign rom_addr  = r_addr;
    assign x_pos     = X_W'(X_ORIGIN) + X_W'(r_col);
    assign y_pos     = Y_W'(Y_ORIGIN) + Y_W'(r_row);
    assign colour    = w_colour;
    assign VGA_write = w_write;
    assign busy      = (r_state == S_FETCH) || (r_state == S_DRAW);
    assign draw_done = (r_state == S_DONE);

endmodule
